alu8_slice_sequencer: RTL and testbench

//  Initiator side of the 8-bit ALU slice interface (A, B, AddSub, shift -> AluOut).

---
 rtl/alu8_slice_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_alu8_slice_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu8_slice_sequencer.sv
// rtl/alu8_slice_sequencer.sv - sequences a 32-bit add/sub/shl over an external 8-bit ALU slice
// Carry/borrow-in is rebuilt with a second correction pass; shift-in is OR-ed into bit 0.
module alu8_slice_sequencer #(
    parameter int NSLICE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [8*NSLICE-1:0] req_a,
    input  logic [8*NSLICE-1:0] req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [8*NSLICE-1:0] rsp_data,
    output logic                rsp_carry,
    output logic [7:0]          alu_a,
    output logic [7:0]          alu_b,
    output logic                alu_addsub,
    output logic                alu_shift,
    input  logic [7:0]          alu_out
);
    localparam int W  = 8 * NSLICE;
    localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [1:0] OP_SUB  = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

    state_t         state_q, state_n;
    logic [1:0]     op_q, op_n;
    logic [W-1:0]   a_q, a_n, b_q, b_n, res_q, res_n;
    logic [IW-1:0]  idx_q, idx_n;
    logic           cin_q, cin_n, c1_q, c1_n, carry_q, carry_n;
    logic [7:0]     r_q, r_n;
    logic [7:0]     alu_a_q, alu_a_n, alu_b_q, alu_b_n;
    logic           alu_addsub_q, alu_addsub_n, alu_shift_q, alu_shift_n;

    logic [7:0]     r1, sres;
    logic           c1, c2, scarry, slice_done;
    logic [W-1:0]   a_sh, b_sh, b_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= OP_SUB;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            idx_q        <= '0;
            cin_q        <= 1'b0;
            c1_q         <= 1'b0;
            r_q          <= '0;
            carry_q      <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_addsub_q <= 1'b0;
            alu_shift_q  <= 1'b0;
        end else begin
            state_q      <= state_n;
            op_q         <= op_n;
            a_q          <= a_n;
            b_q          <= b_n;
            res_q        <= res_n;
            idx_q        <= idx_n;
            cin_q        <= cin_n;
            c1_q         <= c1_n;
            r_q          <= r_n;
            carry_q      <= carry_n;
            alu_a_q      <= alu_a_n;
            alu_b_q      <= alu_b_n;
            alu_addsub_q <= alu_addsub_n;
            alu_shift_q  <= alu_shift_n;
        end
    end

    always_comb begin
        state_n      = state_q;
        op_n         = op_q;
        a_n          = a_q;
        b_n          = b_q;
        res_n        = res_q;
        idx_n        = idx_q;
        cin_n        = cin_q;
        c1_n         = c1_q;
        r_n          = r_q;
        carry_n      = carry_q;
        alu_a_n      = alu_a_q;
        alu_b_n      = alu_b_q;
        alu_addsub_n = alu_addsub_q;
        alu_shift_n  = alu_shift_q;
        slice_done   = 1'b0;
        sres         = '0;
        scarry       = 1'b0;

        // Operands are kept as shift registers so the current slice is always bits [7:0].
        a_sh = a_q >> 8;
        b_sh = b_q >> 8;
        b_in = (req_op == OP_SHL || req_op == OP_PASS) ? '0 : req_b;
        r1   = alu_out | {7'd0, (op_q == OP_SHL) & cin_q};
        case (op_q)
            OP_SUB:  c1 = a_q[7:0] < b_q[7:0];
            OP_SHL:  c1 = a_q[7];
            default: c1 = r1 < a_q[7:0];
        endcase
        c2 = (op_q == OP_SUB) ? (r_q == 8'd0) : (alu_out == 8'd0);

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_n      = PASS1;
                    op_n         = req_op;
                    a_n          = req_a;
                    b_n          = b_in;
                    res_n        = '0;
                    idx_n        = '0;
                    cin_n        = 1'b0;
                    carry_n      = 1'b0;
                    alu_a_n      = req_a[7:0];
                    alu_b_n      = b_in[7:0];
                    alu_addsub_n = (req_op != OP_SUB);
                    alu_shift_n  = (req_op == OP_SHL);
                end
            end
            PASS1: begin
                if (cin_q && (op_q == OP_ADD || op_q == OP_SUB)) begin
                    state_n     = PASS2;
                    r_n         = r1;
                    c1_n        = c1;
                    alu_a_n     = r1;
                    alu_b_n     = 8'h01;
                    alu_shift_n = 1'b0;
                end else begin
                    slice_done = 1'b1;
                    sres       = r1;
                    scarry     = c1;
                end
            end
            PASS2: begin
                slice_done = 1'b1;
                sres       = alu_out;
                scarry     = c1_q | c2;
            end
            DONE: begin
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (slice_done) begin
            res_n = (res_q >> 8) | (W'(sres) << (W - 8));
            cin_n = scarry;
            a_n   = a_sh;
            b_n   = b_sh;
            idx_n = idx_q + 1'b1;
            if (idx_q == IW'(NSLICE - 1)) begin
                state_n      = DONE;
                carry_n      = (op_q == OP_PASS) ? 1'b0 : scarry;
                alu_a_n      = '0;
                alu_b_n      = '0;
                alu_addsub_n = 1'b0;
                alu_shift_n  = 1'b0;
            end else begin
                state_n      = PASS1;
                alu_a_n      = a_sh[7:0];
                alu_b_n      = b_sh[7:0];
                alu_addsub_n = (op_q != OP_SUB);
                alu_shift_n  = (op_q == OP_SHL);
            end
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == DONE);
    assign rsp_data   = res_q;
    assign rsp_carry  = carry_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_addsub = alu_addsub_q;
    assign alu_shift  = alu_shift_q;
endmodule

// File: tb/tb_alu8_slice_sequencer.sv
// tb/tb_alu8_slice_sequencer.sv - scoreboard bench for alu8_slice_sequencer with an 8-bit slice model
module tb_alu8_slice_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_carry;
    logic [7:0]  alu_a, alu_b, alu_out;
    logic        alu_addsub, alu_shift;

    typedef struct {
        logic [31:0] data;
        logic        carry;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    logic [17:0] aq[$];
    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;
    logic        prev_valid = 1'b0;

    alu8_slice_sequencer #(.NSLICE(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry),
        .alu_a(alu_a), .alu_b(alu_b), .alu_addsub(alu_addsub),
        .alu_shift(alu_shift), .alu_out(alu_out)
    );

    // External slice: combinational, no carry in or out.
    assign alu_out = alu_shift ? {alu_a[6:0], 1'b0} : (alu_addsub ? alu_a + alu_b : alu_a - alu_b);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
                end else begin
                    if (!prev_valid) check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                    check("rsp_data", rsp_data, sb[0].data);
                    check("rsp_carry", 32'(rsp_carry), 32'(sb[0].carry));
                    check("req_ready_in_done", 32'(req_ready), 32'd0);
                    if (rsp_ready) void'(sb.pop_front());
                end
            end
            prev_valid = rsp_valid;
        end
    end

    always @(negedge clk) begin
        if (rst_n && !req_ready && !rsp_valid && aq.size() > 0) begin
            logic [17:0] t;
            t = aq.pop_front();
            check("alu_pass_signals", {14'd0, alu_a, alu_b, alu_addsub, alu_shift}, {14'd0, t});
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(req_ready && sb.size() == 0) && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 60) check("wait_idle_timeout", 32'(n), 32'd0);
    endtask

    task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ed, input logic ec, input int lat, input bit push);
        exp_t e;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        req_op    = 2'(op + 2'd1);
        e.data  = ed;
        e.carry = ec;
        e.lat   = lat;
        e.acc   = cyc;
        if (push) sb.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_data"}, rsp_data, 32'd0);
        check({tag, "_rsp_carry"}, 32'(rsp_carry), 32'd0);
        check({tag, "_alu"}, {14'd0, alu_a, alu_b, alu_addsub, alu_shift}, 32'd0);
    endtask

    initial begin
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        wait_idle();
        do_req(2'b01, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 5, 1'b1);

        wait_idle();
        // sub 0-1: slice 0 alone, slices 1..3 get PASS1 then a borrow PASS2 with B=1.
        aq.push_back({8'h00, 8'h01, 1'b0, 1'b0});
        for (int k = 0; k < 3; k++) begin
            aq.push_back({8'h00, 8'h00, 1'b0, 1'b0});
            aq.push_back({8'h00, 8'h01, 1'b0, 1'b0});
        end
        do_req(2'b00, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 7, 1'b1);

        wait_idle();
        for (int k = 0; k < 4; k++) aq.push_back({8'h80, 8'h00, 1'b1, 1'b1});
        do_req(2'b10, 32'h8080_8080, 32'hDEAD_BEEF, 32'h0101_0100, 1'b1, 4, 1'b1);

        wait_idle();
        do_req(2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 7, 1'b1);

        wait_idle();
        do_req(2'b11, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 4, 1'b1);

        wait_idle();
        do_req(2'b01, 32'h89AB_CDEF, 32'h7654_3211, 32'h0000_0000, 1'b1, 7, 1'b1);

        // Back-pressure in DONE with a stray request that must not be taken.
        wait_idle();
        rsp_ready = 1'b0;
        do_req(2'b00, 32'h0000_1000, 32'h0000_0001, 32'h0000_0FFF, 1'b0, 5, 1'b1);
        begin
            int n;
            n = 0;
            while (!rsp_valid && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("hold_reach_done", 32'(rsp_valid), 32'd1);
        end
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_a     = 32'h1111_1111;
        req_b     = 32'h2222_2222;
        repeat (5) @(posedge clk);
        #1;
        check("hold_still_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("after_handshake_idle", {30'd0, req_ready, rsp_valid}, 32'h2);

        // Reset during PASS2 of slice 2 (fifth pass cycle of sub 0-1).
        wait_idle();
        do_req(2'b00, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 7, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("pre_reset_busy", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midop_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("no_rsp_after_abort", 32'(rsp_valid), 32'd0);

        wait_idle();
        do_req(2'b01, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 5, 1'b1);
        wait_idle();

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("alu_trace_drained", 32'(aq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
